irq_pending_arbiter: RTL



---
 rtl/irq_pkg.sv | 14 +
 rtl/irq_edge_det.sv | 24 ++
 rtl/irq_pending_arbiter.sv | 92 +++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared constants and FSM state type for the interrupt pending/grant block.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package irq_pkg;

  localparam int N     = 8;  // request sources, fixed by the external encoder width
  localparam int IDX_W = 3;  // log2(N)

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/irq_edge_det.sv
// Rising-edge detector: registers the request lines and flags 0->1 transitions.
// Latency: rise is combinational from req against last cycle's sample.
// Backpressure: none; it samples every cycle, including while reset is asserted.
module irq_edge_det
  import irq_pkg::*;
#(
  parameter int W = N
) (
  input  logic         clk,
  input  logic [W-1:0] req,
  output logic [W-1:0] rise
);

  logic [W-1:0] req_q;

  // History register. It keeps loading during reset, so lines held high
  // through reset do not look like fresh edges afterwards.
  always_ff @(posedge clk) begin
    req_q <= req;
  end

  assign rise = req & ~req_q;

endmodule

// File: rtl/irq_pending_arbiter.sv
// Sticky pending bits from request edges; grants the encoder's pick over valid/ready.
// Latency: req rises before edge k -> pending at k -> gnt_valid after edge k+1.
// Backpressure: a grant holds (valid and index stable) until gnt_ready; min 1 idle cycle between grants.
// Optional: define IRQ_OVF_EN to add sticky overflow flags (ovf) with a global clear (ovf_clr).
module irq_pending_arbiter
  import irq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  output logic [N-1:0]     pend_o,
  input  logic [IDX_W-1:0] enc_idx_i,
`ifdef IRQ_OVF_EN
  output logic [N-1:0]     ovf,
  input  logic             ovf_clr,
`endif
  output logic             gnt_valid,
  input  logic             gnt_ready,
  output logic [IDX_W-1:0] gnt_idx
);

  state_t       state, state_n;
  logic [N-1:0] rise;
  logic [N-1:0] pending;
  logic [N-1:0] clr_vec;
  logic         any;
  logic         hs;

  irq_edge_det #(.W(N)) u_edge (
    .clk  (clk),
    .req  (req),
    .rise (rise)
  );

  // Masked bits stay pending but are hidden from the encoder until unmasked.
  assign pend_o = pending & mask;
  // Encoder index 0 cannot distinguish "bit 0" from "nothing", so detect here.
  assign any    = |pend_o;
  assign hs     = (state == GRANT) && gnt_ready;
  assign clr_vec = hs ? ({{(N-1){1'b0}}, 1'b1} << gnt_idx) : '0;

  // State, pending bits and the latched grant index. A rise on the bit being
  // cleared wins because the rise term is OR-ed in after the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      gnt_idx <= '0;
    end else begin
      state   <= state_n;
      pending <= (pending & ~clr_vec) | rise;
      if (state == IDLE && any) begin
        gnt_idx <= enc_idx_i;
      end
    end
  end

  // Next state and grant valid. Priority is only sampled in IDLE, so mask or
  // arrival changes during GRANT never disturb the grant in flight.
  always_comb begin
    state_n   = state;
    gnt_valid = 1'b0;
    case (state)
      IDLE: begin
        if (any) begin
          state_n = GRANT;
        end
      end
      GRANT: begin
        gnt_valid = 1'b1;
        if (gnt_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef IRQ_OVF_EN
  // Overflow: an edge on a bit that is already pending and not being serviced
  // this cycle. A set in the same cycle as ovf_clr wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= '0;
    end else begin
      ovf <= (ovf & ~{N{ovf_clr}}) | (rise & pending & ~clr_vec);
    end
  end
`endif

endmodule
